// File: rtl/membus_arbiter_if.sv
// rtl/membus_arbiter_if.sv - Membus request/response bus shared by fetch, load/store and MMIO ports
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEMBUS_DATA_WIDTH
`define MEMBUS_DATA_WIDTH 32
`endif

interface Membus;
  logic                                valid;
  logic                                ready;
  logic [`XLEN-1:0]                    addr;
  logic                                wen;
  logic [`MEMBUS_DATA_WIDTH-1:0]       wdata;
  logic [`MEMBUS_DATA_WIDTH/8-1:0]     wmask;
  logic                                rvalid;
  logic [`MEMBUS_DATA_WIDTH-1:0]       rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - two-requester Membus arbiter with one outstanding transaction
// Define MEMBUS_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority, d_membus first.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef MEMBUS_DATA_WIDTH
`define MEMBUS_DATA_WIDTH 32
`endif

module membus_arbiter (
  input  logic  clk,
  input  logic  rst,
  Membus.slave  i_membus,
  Membus.slave  d_membus,
  Membus.master mem_membus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t                            r_state;
  logic [`XLEN-1:0]                  r_addr;
  logic                              r_wen;
  logic [`MEMBUS_DATA_WIDTH-1:0]     r_wdata;
  logic [`MEMBUS_DATA_WIDTH/8-1:0]   r_wmask;
  logic                              r_owner_d;
`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  logic                              r_last_d;
`endif

  logic w_idle;
  logic w_issue;
  logic w_wait;
  logic w_grant_d;
  logic w_grant_i;
  logic w_resp_d;
  logic w_resp_i;

  // Ready is combinational on valid, so it must also be held low while reset is asserted.
  assign w_idle  = (r_state == IDLE) && rst;
  assign w_issue = (r_state == ISSUE);
  assign w_wait  = (r_state == WAIT_RESP);

`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
  assign w_grant_d = d_membus.valid && (!i_membus.valid || !r_last_d);
`else
  assign w_grant_d = d_membus.valid;
`endif
  assign w_grant_i = i_membus.valid && !w_grant_d;

  assign d_membus.ready = w_idle && w_grant_d;
  assign i_membus.ready = w_idle && w_grant_i;

  assign mem_membus.valid = w_issue;
  assign mem_membus.addr  = w_issue ? r_addr  : '0;
  assign mem_membus.wen   = w_issue ? r_wen   : 1'b0;
  assign mem_membus.wdata = w_issue ? r_wdata : '0;
  assign mem_membus.wmask = w_issue ? r_wmask : '0;

  assign w_resp_d = w_wait && r_owner_d;
  assign w_resp_i = w_wait && !r_owner_d;

  assign d_membus.rvalid = w_resp_d && mem_membus.rvalid;
  assign d_membus.rdata  = w_resp_d ? mem_membus.rdata : '0;
  assign i_membus.rvalid = w_resp_i && mem_membus.rvalid;
  assign i_membus.rdata  = w_resp_i ? mem_membus.rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_wmask   <= '0;
      r_owner_d <= 1'b0;
`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
      r_last_d  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_d || w_grant_i) begin
            r_addr    <= w_grant_d ? d_membus.addr  : i_membus.addr;
            r_wen     <= w_grant_d ? d_membus.wen   : i_membus.wen;
            r_wdata   <= w_grant_d ? d_membus.wdata : i_membus.wdata;
            r_wmask   <= w_grant_d ? d_membus.wmask : i_membus.wmask;
            r_owner_d <= w_grant_d;
`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
            r_last_d  <= w_grant_d;
`endif
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_membus.ready) begin
            r_state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          // Writes also complete only on rvalid, keeping a single outstanding transaction.
          if (mem_membus.rvalid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - directed self-checking bench for membus_arbiter
module tb_membus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  Membus i_bus ();
  Membus d_bus ();
  Membus mem_bus ();

  membus_arbiter u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_membus   (i_bus),
    .d_membus   (d_bus),
    .mem_membus (mem_bus)
  );

  localparam logic [31:0] ADDR_I  = 32'h8000_0000;
  localparam logic [31:0] ADDR_D  = 32'h8000_0100;
  localparam logic [31:0] ADDR_ST = 32'h8000_0200;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_d [4];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [137:0] all_outs();
    return {i_bus.ready, i_bus.rvalid, i_bus.rdata,
            d_bus.ready, d_bus.rvalid, d_bus.rdata,
            mem_bus.valid, mem_bus.addr, mem_bus.wen, mem_bus.wdata, mem_bus.wmask};
  endfunction

  // Entered one step after the grant edge (state ISSUE, mem ready already high); returns in IDLE.
  task automatic txn_complete(input string tag, input bit owner_d, input logic [31:0] exp_addr,
                              input logic [31:0] rd, input int delay);
    smp();
    check({tag, "_mvalid"}, mem_bus.valid, 1'b1);
    check({tag, "_maddr"}, mem_bus.addr, exp_addr);
    cyc();
    for (int k = 0; k < delay; k++) begin
      smp();
      check({tag, "_early_rvalid"}, {i_bus.rvalid, d_bus.rvalid}, 2'b00);
      cyc();
    end
    mem_bus.rvalid = 1'b1;
    mem_bus.rdata  = rd;
    smp();
    check({tag, "_resp_mvalid"}, mem_bus.valid, 1'b0);
    check({tag, "_resp_ready"}, {i_bus.ready, d_bus.ready}, 2'b00);
    if (owner_d) begin
      check({tag, "_d_rsp"}, {d_bus.rvalid, d_bus.rdata, i_bus.rvalid, i_bus.rdata}, {1'b1, rd, 1'b0, 32'h0});
    end else begin
      check({tag, "_i_rsp"}, {i_bus.rvalid, i_bus.rdata, d_bus.rvalid, d_bus.rdata}, {1'b1, rd, 1'b0, 32'h0});
    end
    cyc();
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
`ifdef MEMBUS_ARBITER_ROUND_ROBIN_EN
    exp_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    {i_bus.valid, i_bus.addr, i_bus.wen, i_bus.wdata, i_bus.wmask} = '0;
    {d_bus.valid, d_bus.addr, d_bus.wen, d_bus.wdata, d_bus.wmask} = '0;
    mem_bus.ready = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;

    // Reset with both requesters valid: nothing may be granted
    i_bus.valid = 1'b1; d_bus.valid = 1'b1;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'hAAAA_5555;
    cyc(); cyc();
    smp();
    check("reset_outs", all_outs(), '0);
    cyc();
    i_bus.valid = 1'b0; d_bus.valid = 1'b0; mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    rst = 1'b1;
    smp();
    check("idle_outs", all_outs(), '0);
    cyc();

    // Single fetch
    i_bus.valid = 1'b1; i_bus.addr = ADDR_I; mem_bus.ready = 1'b1;
    smp();
    check("fetch_grant", {i_bus.ready, d_bus.ready, mem_bus.valid}, 3'b100);
    cyc();
    i_bus.valid = 1'b0; i_bus.addr = '0;
    txn_complete("fetch", 1'b0, ADDR_I, 32'h0000_0013, 2);

    // Simultaneous requests: d first, then i right after d's response
    i_bus.valid = 1'b1; i_bus.addr = ADDR_I;
    d_bus.valid = 1'b1; d_bus.addr = ADDR_D;
    smp();
    check("simul_grant_d", {d_bus.ready, i_bus.ready}, 2'b10);
    cyc();
    d_bus.valid = 1'b0;
    txn_complete("simul_d", 1'b1, ADDR_D, 32'h0000_0055, 0);
    smp();
    check("simul_grant_i", {i_bus.ready, d_bus.ready}, 2'b10);
    cyc();
    i_bus.valid = 1'b0;
    txn_complete("simul_i", 1'b0, ADDR_I, 32'h0000_0066, 0);

    // Sustained contention
    i_bus.valid = 1'b1; d_bus.valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      smp();
      check($sformatf("contend_grant%0d", k), {d_bus.ready, i_bus.ready}, {exp_d[k], !exp_d[k]});
      cyc();
      txn_complete($sformatf("contend%0d", k), exp_d[k], exp_d[k] ? ADDR_D : ADDR_I, 32'h100 + k, 0);
    end
    i_bus.valid = 1'b0; d_bus.valid = 1'b0;

    // Store under downstream backpressure
    d_bus.valid = 1'b1; d_bus.addr = ADDR_ST; d_bus.wen = 1'b1;
    d_bus.wdata = 32'hDEAD_BEEF; d_bus.wmask = 4'hF; mem_bus.ready = 1'b0;
    smp();
    check("store_grant", d_bus.ready, 1'b1);
    cyc();
    d_bus.valid = 1'b0; d_bus.addr = '0; d_bus.wen = 1'b0; d_bus.wdata = '0; d_bus.wmask = '0;
    i_bus.valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      smp();
      check($sformatf("bp_req%0d", k),
            {mem_bus.valid, mem_bus.wen, mem_bus.wmask, mem_bus.wdata, mem_bus.addr},
            {1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, ADDR_ST});
      check($sformatf("bp_ready%0d", k), {i_bus.ready, d_bus.ready}, 2'b00);
      cyc();
    end
    mem_bus.ready = 1'b1;
    txn_complete("store", 1'b1, ADDR_ST, 32'h0, 1);
    smp();
    check("after_store_grant_i", {i_bus.ready, d_bus.ready}, 2'b10);
    cyc();
    i_bus.valid = 1'b0;
    txn_complete("after_store_i", 1'b0, ADDR_I, 32'h0000_0077, 0);

    // Spurious response while idle
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0000_1234;
    for (int k = 0; k < 2; k++) begin
      smp();
      check($sformatf("spur_rsp%0d", k), {i_bus.rvalid, i_bus.rdata, d_bus.rvalid, d_bus.rdata}, '0);
      check($sformatf("spur_mvalid%0d", k), mem_bus.valid, 1'b0);
      cyc();
    end
    mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    d_bus.valid = 1'b1; d_bus.addr = ADDR_D;
    smp();
    check("spur_then_grant", d_bus.ready, 1'b1);
    cyc();
    d_bus.valid = 1'b0;
    txn_complete("spur_after", 1'b1, ADDR_D, 32'h0000_0088, 0);

    // Reset during WAIT_RESP, then a late response
    i_bus.valid = 1'b1; i_bus.addr = ADDR_I;
    smp();
    check("rst_txn_grant", i_bus.ready, 1'b1);
    cyc();
    i_bus.valid = 1'b0;
    cyc();
    rst = 1'b0;
    i_bus.valid = 1'b1; d_bus.valid = 1'b1;
    mem_bus.rvalid = 1'b1; mem_bus.rdata = 32'h0000_0099;
    #1;
    check("rst_mid_outs", all_outs(), '0);
    cyc();
    smp();
    check("rst_hold_outs", all_outs(), '0);
    cyc();
    rst = 1'b1; d_bus.valid = 1'b0;
    smp();
    check("late_rsp_idle", {i_bus.ready, i_bus.rvalid, i_bus.rdata}, {1'b1, 1'b0, 32'h0});
    cyc();
    i_bus.valid = 1'b0;
    #1;
    check("late_rsp_issue", {i_bus.rvalid, i_bus.rdata, mem_bus.valid}, {1'b0, 32'h0, 1'b1});
    mem_bus.rvalid = 1'b0; mem_bus.rdata = '0;
    txn_complete("post_rst", 1'b0, ADDR_I, 32'h0000_00AA, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/membus_arbiter.md
MEMBUS_ARBITER -- requirements
Module: membus_arbiter

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- i_membus  Membus.slave  -  instruction-fetch requester
- d_membus  Membus.slave  -  load/store requester
- mem_membus  Membus.master  -  shared downstream port (to the MMIO controller)
REQ-002 The Membus fields SHALL be valid, ready, addr[XLEN-1:0], wen, wdata[MEMBUS_DATA_WIDTH-1:0], wmask[MEMBUS_DATA_WIDTH/8-1:0], rvalid and rdata[MEMBUS_DATA_WIDTH-1:0].
REQ-003 The block SHALL have no parameters; widths come from XLEN and MEMBUS_DATA_WIDTH.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, ISSUE and WAIT_RESP, and SHALL hold at most one outstanding transaction.
REQ-005 In IDLE, with at least one requester valid, the block SHALL select one winner, assert ready only to the winner in that cycle, latch its addr/wen/wdata/wmask, record the owner, and go to ISSUE.
REQ-006 In IDLE with no requester valid, the state SHALL remain IDLE.
REQ-007 In any state other than IDLE, i_membus.ready and d_membus.ready SHALL be 0.
REQ-008 A losing requester's ready SHALL be 0, and it SHALL keep valid asserted until granted; its request is not latched.
REQ-009 In ISSUE, mem_membus.valid SHALL be 1 and its addr/wen/wdata/wmask SHALL equal the latched request.
REQ-010 In ISSUE, on mem_membus.ready=1 the FSM SHALL go to WAIT_RESP; otherwise it SHALL hold, with the request stable.
REQ-011 In IDLE and WAIT_RESP, mem_membus.valid SHALL be 0 and addr/wen/wdata/wmask SHALL be 0.
REQ-012 In WAIT_RESP, mem_membus.rvalid and rdata SHALL pass combinationally to the owner's rvalid and rdata in the same cycle. The non-owner SHALL see rvalid=0 and rdata=0. On rvalid=1 the FSM SHALL return to IDLE.
REQ-013 mem_membus.rvalid asserted in IDLE or ISSUE SHALL be ignored, with no forwarding and no state change.
REQ-014 Minimum latency SHALL be:
- request accepted in cycle T
- downstream valid in cycle T+1
- response forwarded in the cycle downstream asserts rvalid
- next grant in the cycle after the response, at the earliest
REQ-015 A new grant SHALL NOT occur in the same cycle as a response; the response cycle is in WAIT_RESP, not IDLE.
REQ-016 For write transactions (wen=1), the block SHALL still wait for rvalid before returning to IDLE.

Reset
REQ-017 While rst=0, the block SHALL:
- set the state to IDLE
- clear the latched request, owner and priority pointer to 0
- drive all ready, valid and rvalid outputs to 0 and all data/addr/mask outputs to 0.
REQ-018 Reset asserted during ISSUE or WAIT_RESP SHALL abandon the transaction immediately. A late downstream rvalid after reset release SHALL be ignored per REQ-013.

Configuration
REQ-019 With macro MEMBUS_ARBITER_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin:
- a 1-bit last-grant pointer updates on every grant
- on simultaneous requests, the requester not granted last wins
- after reset the pointer selects d_membus first.
REQ-020 Without MEMBUS_ARBITER_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with d_membus over i_membus, and no pointer register exists.

Verification
REQ-021 Single fetch, i valid addr=0x8000_0000, mem ready immediately, rvalid 3 cycles later with rdata=0x0000_0013 -> i.ready=1 for 1 cycle; mem.valid=1 one cycle later with the same addr; i.rvalid=1 with rdata=0x13; d.rvalid stays 0.
REQ-022 Simultaneous requests, i addr=0x8000_0000 and d addr=0x8000_0100 held valid -> d granted first (both modes). Then i granted in the cycle after d's rvalid. mem.addr sequence: 0x8000_0100, then 0x8000_0000.
REQ-023 Sustained contention with both valid continuously for 4 transactions -> round-robin: grant order d,i,d,i. Fixed priority: d,d,d,d with i ready=0 throughout.
REQ-024 Downstream backpressure, mem.ready=0 for 5 cycles in ISSUE with a store (wen=1, wdata=0xDEAD_BEEF, wmask=0xF) -> mem.valid and fields stable for all 5 cycles. No requester sees ready=1 until the response completes.
REQ-025 Spurious response, mem.rvalid=1 in IDLE with rdata=0x1234 -> no requester rvalid and the state stays IDLE.
REQ-026 Reset in WAIT_RESP: assert rst=0 mid-transaction, then apply a late mem.rvalid -> all outputs 0 during reset; the response is dropped; the next i request is granted normally.
